// File: rtl/key_debounce_events.sv
// Four-key push-button front end: two-flop synchronizer, debounce FSM and
// long-press timer per key, producing clean levels and one-cycle event pulses.
module key_debounce_events #(
    parameter int CLOCK_FREQ      = 50_000_000,
    parameter int DEBOUNCE_CYCLES = CLOCK_FREQ / 50,
    parameter int LONG_CYCLES     = CLOCK_FREQ
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] KEY,
    output logic [3:0] KEY_STATE,
    output logic [3:0] KEY_PRESS,
    output logic [3:0] KEY_RELEASE,
    output logic [3:0] KEY_LONG
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [3:0]    sync_1;
    logic [3:0]    sync_2;
    state_t        state     [4];
    logic [DW-1:0] dcnt      [4];
    logic [HW-1:0] hcnt      [4];
    logic [3:0]    long_done;
    logic [3:0]    rel_done;

    // A release accepted on the same edge as the long-press threshold wins,
    // so KEY_LONG and KEY_RELEASE never coincide for one key.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        rel_done = '0;
        for (int i = 0; i < 4; i++) begin
            rel_done[i] = (state[i] == RELEASE_WAIT) && sync_2[i] && (dcnt[i] == D_LAST);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the per-key counter arrays are small flops, not RAM, so they
            // are cleared with everything else; a mid-press reset restarts debounce.
            sync_1      <= '1;
            sync_2      <= '1;
            KEY_STATE   <= '0;
            KEY_PRESS   <= '0;
            KEY_RELEASE <= '0;
            KEY_LONG    <= '0;
            long_done   <= '0;
            for (int i = 0; i < 4; i++) begin
                state[i] <= IDLE;
                dcnt[i]  <= '0;
                hcnt[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync_1      <= KEY;
            sync_2      <= sync_1;
            KEY_PRESS   <= '0;
            KEY_RELEASE <= '0;
            KEY_LONG    <= '0;

            for (int i = 0; i < 4; i++) begin
                if (state[i] == PRESSED || state[i] == RELEASE_WAIT) begin
                    if (hcnt[i] != H_LAST) begin
                        hcnt[i] <= hcnt[i] + 1'b1;
                    end else if (!long_done[i] && !rel_done[i]) begin
                        KEY_LONG[i]  <= 1'b1;
                        long_done[i] <= 1'b1;
                    end
                end

                case (state[i])
                    IDLE: begin
                        if (!sync_2[i]) begin
                            state[i] <= PRESS_WAIT;
                            dcnt[i]  <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (sync_2[i]) begin
                            state[i] <= IDLE;
                        end else if (dcnt[i] == D_LAST) begin
                            state[i]     <= PRESSED;
                            KEY_STATE[i] <= 1'b1;
                            KEY_PRESS[i] <= 1'b1;
                            hcnt[i]      <= '0;
                            long_done[i] <= 1'b0;
                        end else begin
                            dcnt[i] <= dcnt[i] + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (sync_2[i]) begin
                            state[i] <= RELEASE_WAIT;
                            dcnt[i]  <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (!sync_2[i]) begin
                            state[i] <= PRESSED;
                        end else if (rel_done[i]) begin
                            state[i]       <= IDLE;
                            KEY_STATE[i]   <= 1'b0;
                            KEY_RELEASE[i] <= 1'b1;
                        end else begin
                            dcnt[i] <= dcnt[i] + 1'b1;
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_debounce_events.sv
// Self-checking bench: every cycle the pulse outputs are compared against a
// scoreboard of expected events scheduled when each stimulus is applied.
module tb_key_debounce_events;

    localparam int DEB = 8;
    localparam int LNG = 32;
    localparam int LAT = DEB + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic [3:0]  lng;
    } ev_t;

    typedef struct {
        int key_idx;
        int low;
        bit press;
        bit lng;
    } vec_t;

    ev_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    bit          mon_en = 1'b0;

    key_debounce_events #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .KEY        (key),
        .KEY_STATE  (key_state),
        .KEY_PRESS  (key_press),
        .KEY_RELEASE(key_release),
        .KEY_LONG   (key_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected events are kept sorted by cycle; events landing on one cycle merge.
    function automatic void push_ev(input int unsigned c, input logic [3:0] p,
                                    input logic [3:0] r, input logic [3:0] l);
        ev_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.lng   = l;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc == c) begin
                e.press  = e.press | exp_q[i].press;
                e.rel    = e.rel | exp_q[i].rel;
                e.lng    = e.lng | exp_q[i].lng;
                exp_q[i] = e;
                return;
            end
            if (exp_q[i].cyc > c) begin
                exp_q.insert(i, e);
                return;
            end
        end
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            e.cyc   = cyc;
            e.press = 4'h0;
            e.rel   = 4'h0;
            e.lng   = 4'h0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
            check($sformatf("pulses@%0d press/release/long", cyc),
                  {20'd0, key_press, key_release, key_long},
                  {20'd0, e.press, e.rel, e.lng});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_state(input string name, input logic [3:0] exp);
        check(name, {28'd0, key_state}, {28'd0, exp});
    endtask

    vec_t        vecs [8];
    int unsigned n;
    logic [3:0]  m;

    initial begin
        vecs = '{
            '{0,   7, 1'b0, 1'b0},
            '{0,   9, 1'b1, 1'b0},
            '{1,  20, 1'b1, 1'b0},
            '{2, 100, 1'b1, 1'b1},
            '{3,   3, 1'b0, 1'b0},
            '{1,  31, 1'b1, 1'b0},
            '{2,  33, 1'b1, 1'b1},
            '{3,  10, 1'b1, 1'b0}
        };

        // Reset held with all keys down, then all four press together.
        rst = 1'b1;
        key = 4'h0;
        tick(1);
        mon_en = 1'b1;
        check_state("state_in_reset_1", 4'h0);
        tick(1);
        check_state("state_in_reset_2", 4'h0);
        tick(1);
        check_state("state_in_reset_3", 4'h0);
        rst = 1'b0;
        n = cyc;
        push_ev(n + LAT, 4'hF, 4'h0, 4'h0);
        tick(LAT - 1);
        check_state("state_before_press", 4'h0);
        tick(1);
        check_state("state_at_press", 4'hF);
        tick(20 - LAT);
        key = 4'hF;
        push_ev(n + 20 + LAT, 4'h0, 4'hF, 4'h0);
        tick(LAT - 1);
        check_state("state_before_release", 4'hF);
        tick(1);
        check_state("state_at_release", 4'h0);
        tick(4);

        // Single-key press/hold vectors: glitches, clean presses, long presses.
        for (int i = 0; i < 8; i++) begin
            n = cyc;
            m = 4'b0001 << vecs[i].key_idx;
            key[vecs[i].key_idx] = 1'b0;
            if (vecs[i].press) push_ev(n + LAT, m, 4'h0, 4'h0);
            if (vecs[i].lng) push_ev(n + LAT + LNG, 4'h0, 4'h0, m);
            if (vecs[i].low > LAT) begin
                tick(LAT);
                check_state($sformatf("vec%0d_state_held", i), vecs[i].press ? m : 4'h0);
                tick(vecs[i].low - LAT);
            end else begin
                tick(vecs[i].low);
            end
            key[vecs[i].key_idx] = 1'b1;
            if (vecs[i].press) push_ev(n + vecs[i].low + LAT, 4'h0, m, 4'h0);
            tick(LAT + 4);
            check_state($sformatf("vec%0d_state_idle", i), 4'h0);
        end

        // KEY[0] chattering every 3 cycles never settles long enough.
        for (int i = 0; i < 40; i++) begin
            key[0] = ((i / 3) % 2) == 1;
            tick(1);
        end
        key[0] = 1'b1;
        tick(15);
        check_state("bounce_state", 4'h0);

        // Release bounce on KEY[3]: 5 high cycles mid-press are ignored.
        n = cyc;
        key[3] = 1'b0;
        push_ev(n + LAT, 4'b1000, 4'h0, 4'h0);
        push_ev(n + LAT + LNG, 4'h0, 4'h0, 4'b1000);
        tick(20);
        check_state("rel_bounce_pressed", 4'b1000);
        key[3] = 1'b1;
        tick(5);
        key[3] = 1'b0;
        tick(10);
        check_state("rel_bounce_still_pressed", 4'b1000);
        tick(25);
        key[3] = 1'b1;
        push_ev(n + 60 + LAT, 4'h0, 4'b1000, 4'h0);
        tick(LAT + 4);
        check_state("rel_bounce_released", 4'h0);

        // Simultaneous press on KEY[0] and KEY[3], then reset while held.
        n = cyc;
        key = 4'b0110;
        push_ev(n + LAT, 4'b1001, 4'h0, 4'h0);
        tick(LAT);
        check_state("dual_press_state", 4'b1001);
        tick(9);
        rst = 1'b1;
        tick(1);
        check_state("mid_reset_state", 4'h0);
        tick(1);
        rst = 1'b0;
        n = cyc;
        push_ev(n + LAT, 4'b1001, 4'h0, 4'h0);
        tick(LAT - 1);
        check_state("post_reset_not_yet", 4'h0);
        tick(1);
        check_state("post_reset_repress", 4'b1001);
        tick(4);
        key = 4'hF;
        push_ev(cyc + LAT, 4'h0, 4'b1001, 4'h0);
        tick(LAT + 4);
        check_state("final_state", 4'h0);

        check("events_all_seen", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
